// File: rtl/perf_monitor_unit.sv
// ============================================================================
// perf_monitor_unit : cycle/retire counters with serial fixed-point IPC divide
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_monitor_unit #(
   parameter int CNT_W  = 32,
   parameter int FRAC_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic        clr_i,
   input  logic        rd_en_i,
   input  logic [1:0]  rd_addr_i,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   output logic        running_o,
   output logic        done_o,
   output logic        overflow_o
);

   localparam int DIV_W  = CNT_W + FRAC_W;
   localparam int STEP_W = $clog2(DIV_W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cycle_cnt;
   logic [CNT_W-1:0]    instr_cnt;
   logic [15:0]         ipc_q;
   logic [31:0]         prev_pc_q;
   logic                overflow;
   logic                done_flag;
   logic                done_q;
   logic [DIV_W-1:0]    div_dvd;
   logic [DIV_W-1:0]    div_quo;
   logic [CNT_W-1:0]    div_rem;
   logic [CNT_W-1:0]    div_dsr;
   logic [STEP_W-1:0]   div_step;
   logic [31:0]         rd_data_q;
   logic                rd_valid_q;

   logic                retire;
   logic                cyc_max;
   logic                ins_max;
   logic [CNT_W-1:0]    cyc_nxt;
   logic [CNT_W-1:0]    ins_nxt;
   logic [CNT_W:0]      rem_shift;
   logic                rem_ge;
   logic [CNT_W-1:0]    rem_sub;
   logic [DIV_W-1:0]    quo_next;
   logic [15:0]         ipc_sat;
   logic                div_last;
   logic [31:0]         rd_mux;

   assign retire   = (pc_i != prev_pc_q) && (pc_i != '0);
   assign cyc_max  = &cycle_cnt;
   assign ins_max  = &instr_cnt;
   assign cyc_nxt  = cyc_max ? cycle_cnt : cycle_cnt + 1'b1;
   assign ins_nxt  = (retire && !ins_max) ? instr_cnt + 1'b1 : instr_cnt;

   // Remainder stays below the divisor, so the subtraction fits in CNT_W bits.
   assign rem_shift = {div_rem, div_dvd[DIV_W-1]};
   assign rem_ge    = rem_shift >= {1'b0, div_dsr};
   assign rem_sub   = rem_shift[CNT_W-1:0] - div_dsr;
   assign quo_next  = {div_quo[DIV_W-2:0], rem_ge};
   assign div_last  = (div_step == STEP_W'(DIV_W - 1));

   generate
      if (DIV_W > 16) begin : g_ipc_clip
         assign ipc_sat = (|quo_next[DIV_W-1:16]) ? 16'hFFFF : quo_next[15:0];
      end else begin : g_ipc_ext
         assign ipc_sat = 16'(quo_next);
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      prev_pc_q <= pc_i;
      done_q    <= 1'b0;
      if (rst_i || clr_i) begin
         state     <= S_IDLE;
         cycle_cnt <= '0;
         instr_cnt <= '0;
         ipc_q     <= '0;
         overflow  <= 1'b0;
         done_flag <= 1'b0;
         div_dvd   <= '0;
         div_quo   <= '0;
         div_rem   <= '0;
         div_dsr   <= '0;
         div_step  <= '0;
         if (rst_i) begin
            prev_pc_q <= '0;
         end
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state     <= S_RUN;
                  cycle_cnt <= '0;
                  instr_cnt <= '0;
                  ipc_q     <= '0;
                  overflow  <= 1'b0;
                  done_flag <= 1'b0;
               end
            end
            S_RUN: begin
               cycle_cnt <= cyc_nxt;
               instr_cnt <= ins_nxt;
               if (cyc_max || (retire && ins_max)) begin
                  overflow <= 1'b1;
               end
               // The stop cycle is counted, so the divider loads the updated values.
               if (stop_i) begin
                  state    <= S_DIV;
                  div_dvd  <= {ins_nxt, {FRAC_W{1'b0}}};
                  div_dsr  <= cyc_nxt;
                  div_rem  <= '0;
                  div_quo  <= '0;
                  div_step <= '0;
               end
            end
            S_DIV: begin
               div_dvd  <= div_dvd << 1;
               div_rem  <= rem_ge ? rem_sub : rem_shift[CNT_W-1:0];
               div_quo  <= quo_next;
               div_step <= div_step + 1'b1;
               if (div_last) begin
                  state     <= S_DONE;
                  ipc_q     <= ipc_sat;
                  done_q    <= 1'b1;
                  done_flag <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_addr_i)
         2'd0:    rd_mux = 32'(cycle_cnt);
         2'd1:    rd_mux = 32'(instr_cnt);
         2'd2:    rd_mux = {16'b0, ipc_q};
         default: rd_mux = {27'b0, (state == S_DIV), done_flag, overflow,
                            (state == S_DONE), (state == S_RUN)};
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_en_i;
         rd_data_q  <= rd_en_i ? rd_mux : '0;
      end
   end

   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign running_o  = (state == S_RUN);
   assign done_o     = done_q;
   assign overflow_o = overflow;

endmodule

`default_nettype wire

// File: tb/tb_perf_monitor_unit.sv
// ============================================================================
// tb_perf_monitor_unit : directed checks for perf_monitor_unit (CNT_W=32 and 4)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_monitor_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        clr = 1'b0;
   logic        rd_en = 1'b0;
   logic [1:0]  rd_addr = '0;

   logic [31:0] rd_data,  s_rd_data;
   logic        rd_valid, s_rd_valid;
   logic        running,  s_running;
   logic        done,     s_done;
   logic        overflow, s_overflow;

   int tests  = 0;
   int failed = 0;
   int n;

   always #5 clk = ~clk;

   perf_monitor_unit #(.CNT_W(32), .FRAC_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .start_i(start), .stop_i(stop),
      .clr_i(clr), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data), .rd_valid_o(rd_valid), .running_o(running),
      .done_o(done), .overflow_o(overflow)
   );

   perf_monitor_unit #(.CNT_W(4), .FRAC_W(8)) dut_s (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .start_i(start), .stop_i(stop),
      .clr_i(clr), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
      .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid), .running_o(s_running),
      .done_o(s_done), .overflow_o(s_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      rd_en   = 1'b1;
      rd_addr = addr;
      step();
      chk({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
      chk(tag, rd_data, exp);
   endtask

   task automatic s_rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      rd_en   = 1'b1;
      rd_addr = addr;
      step();
      chk({tag, "_valid"}, {31'b0, s_rd_valid}, 32'd1);
      chk(tag, s_rd_data, exp);
   endtask

   task automatic wait_done(input string tag, input int limit, input int exp_lat);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         step();
         n++;
      end
      chk(tag, n, exp_lat);
   endtask

   initial begin
      int pcs [6] = '{4, 8, 8, 12, 0, 16};
      int dcnt;

      // Reset state
      step(); step();
      chk("rst_rd_data",  rd_data, 0);
      chk("rst_rd_valid", {31'b0, rd_valid}, 0);
      chk("rst_running",  {31'b0, running}, 0);
      chk("rst_done",     {31'b0, done}, 0);
      chk("rst_overflow", {31'b0, overflow}, 0);
      rst = 1'b0;
      step();

      // stop in IDLE does nothing
      stop = 1'b1; step(); stop = 1'b0;
      chk("idle_stop_running", {31'b0, running}, 0);
      rd_chk("idle_stop_status", 2'd3, 32'h0);
      rd_en = 1'b0;

      // Basic run: 6 cycles, 4 retires
      pc = 0; start = 1'b1; step(); start = 1'b0;
      chk("basic_running", {31'b0, running}, 1);
      for (int i = 0; i < 6; i++) begin
         pc   = pcs[i];
         stop = (i == 5);
         step();
      end
      stop = 1'b0;
      chk("basic_left_run", {31'b0, running}, 0);
      wait_done("basic_div_latency", 100, 40);
      step();
      chk("basic_done_pulse", {31'b0, done}, 0);
      chk("basic_idle_valid", {31'b0, rd_valid}, 0);
      chk("basic_idle_data",  rd_data, 0);
      rd_chk("basic_cycles", 2'd0, 32'd6);
      rd_chk("basic_instrs", 2'd1, 32'd4);
      rd_chk("basic_ipc",    2'd2, 32'h00AA);
      rd_chk("basic_status", 2'd3, 32'h0A);
      rd_en = 1'b0;
      step();
      chk("rd_after_valid", {31'b0, rd_valid}, 0);
      chk("rd_after_data",  rd_data, 0);
      chk("basic_overflow", {31'b0, overflow}, 0);

      // Full throughput: restart from DONE, 100 retires in 100 cycles
      pc = 100; start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         pc   = 100 + 4 * k;
         stop = (k == 100);
         step();
      end
      stop = 1'b0;
      wait_done("full_div_latency", 100, 40);
      rd_chk("full_cycles", 2'd0, 32'd100);
      rd_chk("full_instrs", 2'd1, 32'd100);
      rd_chk("full_ipc",    2'd2, 32'h0100);
      rd_en = 1'b0;
      chk("full_overflow", {31'b0, overflow}, 0);

      // Saturation on the CNT_W=4 instance: 20 cycles of retires
      pc = 1000; start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         pc   = 1000 + 4 * k;
         stop = (k == 20);
         step();
      end
      stop = 1'b0;
      chk("sat_overflow_o", {31'b0, s_overflow}, 1);
      n = 0;
      while (s_done !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("sat_div_latency", n, 12);
      s_rd_chk("sat_cycles", 2'd0, 32'd15);
      s_rd_chk("sat_instrs", 2'd1, 32'd15);
      s_rd_chk("sat_ipc",    2'd2, 32'h0100);
      s_rd_chk("sat_status", 2'd3, 32'h0E);
      rd_en = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("wide_done_seen", {31'b0, done}, 1);
      rd_chk("wide_cycles", 2'd0, 32'd20);
      rd_chk("wide_instrs", 2'd1, 32'd20);
      rd_chk("wide_ipc",    2'd2, 32'h0100);
      rd_en = 1'b0;

      // clr from DONE zeroes everything
      clr = 1'b1; step(); clr = 1'b0;
      chk("clr_running", {31'b0, running}, 0);
      rd_chk("clr_cycles", 2'd0, 32'd0);
      rd_chk("clr_instrs", 2'd1, 32'd0);
      rd_chk("clr_ipc",    2'd2, 32'd0);
      rd_chk("clr_status", 2'd3, 32'd0);
      rd_en = 1'b0;

      // start+stop together in IDLE: start wins; start in RUN does not clear
      pc = 2000; start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      chk("startstop_running", {31'b0, running}, 1);
      step(); step(); step();
      rd_chk("startstop_cycles", 2'd0, 32'd3);
      start = 1'b1;
      rd_chk("run_start_cycles", 2'd0, 32'd4);
      start = 1'b0;
      rd_chk("run_noclear_cycles", 2'd0, 32'd5);
      rd_en = 1'b0;
      chk("run_start_running", {31'b0, running}, 1);

      // clr 10 cycles into DIV: abandoned, no done pulse
      stop = 1'b1; step(); stop = 1'b0;
      repeat (10) step();
      clr = 1'b1; step(); clr = 1'b0;
      chk("abort_running", {31'b0, running}, 0);
      dcnt = (done === 1'b1) ? 1 : 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (done === 1'b1) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      rd_chk("abort_cycles", 2'd0, 32'd0);
      rd_chk("abort_instrs", 2'd1, 32'd0);
      rd_chk("abort_ipc",    2'd2, 32'd0);
      rd_chk("abort_status", 2'd3, 32'd0);
      rd_en = 1'b0;

      // rst during RUN with a read in flight
      pc = 3000; start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         pc = 3000 + 4 * k;
         step();
      end
      rd_en = 1'b1; rd_addr = 2'd3; rst = 1'b1;
      step();
      chk("runrst_rd_valid", {31'b0, rd_valid}, 0);
      chk("runrst_rd_data",  rd_data, 0);
      chk("runrst_running",  {31'b0, running}, 0);
      chk("runrst_done",     {31'b0, done}, 0);
      chk("runrst_overflow", {31'b0, overflow}, 0);
      rst = 1'b0; rd_en = 1'b0;
      step();
      rd_chk("runrst_cycles", 2'd0, 32'd0);
      rd_en = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/perf_monitor_unit.md
Name: perf_monitor_unit

Overview:
- In-RTL performance monitor that measures IPC in hardware, so IPC is no longer only computed by a bench.
- Watches the core's retire-PC debug stream and counts cycles and retired instructions between a start event and a stop event.
- When stop arrives, computes IPC in fixed point with a serial divider.
- Exposes results through a small word-addressed read port for the LSU/IO map or a bench; one instance per pipeline variant (forwarding / nop).

Parameters:
- CNT_W, 32, width of cycle and instruction counters (saturating)
- FRAC_W, 8, fractional bits of the IPC result (IPC reported as Q(16-FRAC_W).FRAC_W in 16 bits)

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- pc_i  input  32  retire PC from core (pc_debug)
- start_i  input  1  single-cycle pulse: clear counters and begin measurement
- stop_i  input  1  single-cycle pulse: end measurement (e.g. program-done detect)
- clr_i  input  1  abort and return to IDLE with all results zeroed
- rd_en_i  input  1  read request
- rd_addr_i  input  2  word index: 0 cycles, 1 instrs, 2 ipc, 3 status
- rd_data_o  output  32  read data, 0 when rd_valid_o=0
- rd_valid_o  output  1  rd_data_o valid (one cycle after rd_en_i)
- running_o  output  1  state==RUN
- done_o  output  1  one-cycle pulse when IPC result becomes valid
- overflow_o  output  1  sticky: a counter saturated during this measurement

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; cycle_cnt, instr_cnt, ipc_q, prev_pc_q, divider regs = 0.
  - rd_data_o, rd_valid_o, running_o, done_o, overflow_o = 0.
- Priority each cycle: rst_i > clr_i > start_i/stop_i.
- prev_pc_q <= pc_i every cycle, in all states.
- Retire event: pc_i != prev_pc_q AND pc_i != 0.
- States: IDLE, RUN, DIV, DONE.
  - IDLE:
    - start_i -> RUN; cycle_cnt, instr_cnt, ipc_q, overflow cleared.
    - stop_i ignored; start_i with stop_i in the same cycle means start wins.
  - RUN, every cycle:
    - cycle_cnt += 1.
    - instr_cnt += 1 on a retire event.
    - Both saturate at 2^CNT_W-1; if either saturates, overflow set.
    - start_i ignored.
    - stop_i: the stop cycle itself is counted, then -> DIV.
  - DIV (serial restoring divider):
    - Dividend = instr_cnt << FRAC_W, (CNT_W+FRAC_W) bits; divisor = cycle_cnt (>=1 by construction).
    - One quotient bit per cycle, exactly CNT_W+FRAC_W cycles.
    - ipc_q = min(quotient, 16'hFFFF); then -> DONE with done_o=1 for that one cycle.
    - start_i, stop_i ignored.
  - DONE:
    - All results held.
    - start_i -> RUN, clearing as in IDLE.
    - stop_i ignored.
- clr_i in any state: -> IDLE, all counters/results/overflow zeroed next cycle; a divide in progress is abandoned and no done_o pulse is issued.
- Read port:
  - Registered, latency 1: rd_valid_o=1 in the cycle after rd_en_i=1.
  - Data reflects register values at the rd_en_i edge, i.e. before that cycle's update.
  - Addr 0: cycle_cnt, zero-extended to 32.
  - Addr 1: instr_cnt, zero-extended to 32.
  - Addr 2: {16'b0, ipc_q}.
  - Addr 3: {27'b0, div_busy, done_flag, overflow, halted(DONE), running}. done_flag is sticky in DONE.
  - Back-to-back reads allowed every cycle.
  - ipc_q reads 0 until DONE.
- Arithmetic: counters unsigned; no wrap (saturation only). Quotient truncated (floor).

Test Plan:
- Basic:
  - Stimulus: pc_i=0 with start_i at T; pc_i at T+1..T+6 = 4,8,8,12,0,16; stop_i at T+6.
  - Response: cycles=6, instrs=4 (repeat 8 and the 0 excluded).
  - done_o exactly CNT_W+FRAC_W=40 cycles after DIV entry; ipc=floor(4*256/6)=170 (0x00AA); overflow=0.
- Full throughput:
  - Stimulus: PC increments by 4 every cycle for 100 cycles, then stop.
  - Response: cycles=100, instrs=100, ipc=256 (0x0100).
- Saturation:
  - Stimulus: CNT_W=4, run 20 cycles with PC changing every cycle.
  - Response: cycles=15, instrs=15, overflow_o=1, status bit1=1, ipc=256.
- Control edge cases:
  - Stimulus: start_i and stop_i together in IDLE.
  - Response: enters RUN, keeps counting.
  - Stimulus: start_i during RUN.
  - Response: no clear.
  - Stimulus: stop_i in IDLE.
  - Response: no state change.
- Abort:
  - Stimulus: clr_i asserted 10 cycles into DIV.
  - Response: IDLE next cycle; all reads return 0; no done_o pulse.
  - Stimulus: rst_i during RUN.
  - Response: all outputs 0 on the next edge.
- Read port:
  - Stimulus: rd_en_i on consecutive cycles with addr 0,1,2,3 while in DONE.
  - Response: rd_valid_o high for 4 cycles starting 1 cycle later, data in order; rd_data_o=0 whenever rd_valid_o=0.
